dds_chirp_responder: RTL and testbench
======================================

Name: dds_chirp_responder

Overview:
- Receiving end of the REQ/ACK configuration handshake issued by the pulse-timing master.
- Synchronizes REQ and captures the DDS word set (start frequency, frequency step, step rate) into shadow registers, then acknowledges with a four-phase handshake.
- On a DDS_start rising edge it loads the shadow set into the active chirp generator: a phase accumulator whose frequency word is stepped linearly at a programmable rate. Its output phase feeds the sine LUT/DAC path.

Parameters:
- PHASE_W, 48: phase accumulator and frequency word width.
- RATE_W, 32: step-rate counter width.
- OUT_W, 16: phase output width (top bits of the accumulator).
- SYNC_STAGES, 2: flip-flop stages on the REQ and DDS_start synchronizers (minimum 2).

Ports:
- CLK  in  1  DDS clock (all logic).
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  1  config request from the master, asynchronous to CLK.
- ACK  out  1  config acknowledge, registered.
- DDS_freq  in  PHASE_W  start frequency word; stable while REQ=1.
- DDS_delta_freq  in  PHASE_W  frequency increment per step; stable while REQ=1.
- DDS_delta_rate  in  RATE_W  clock cycles per frequency step; 0 means no sweep.
- DDS_start  in  1  run enable from the master, asynchronous to CLK.
- PHASE  out  OUT_W  acc[PHASE_W-1 -: OUT_W].
- FREQ_CUR  out  PHASE_W  active frequency word.
- RUN  out  1  chirp generator active.
- CFG_VALID  out  1  at least one configuration captured since reset.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - ACK, RUN, CFG_VALID, PHASE, FREQ_CUR and all synchronizer flops to 0.
  - Shadow and active registers to 0.
  - Both FSMs to their IDLE states.
- Synchronizers: req_s and start_s are the outputs of SYNC_STAGES-deep flop chains. A start_s edge detect uses one extra flop.
- Handshake FSM:
  - H_IDLE (ACK=0): when req_s=1, capture DDS_freq, DDS_delta_freq and DDS_delta_rate into the shadow registers, set CFG_VALID, go to H_ACK.
  - H_ACK (ACK=1): when req_s=0, go to H_IDLE, with ACK=0 from the next cycle.
  - ACK rises on the first clock after the capture edge, i.e. SYNC_STAGES+1 CLK edges after REQ rises. ACK falls SYNC_STAGES+1 edges after REQ falls.
  - REQ pulses shorter than the synchronizer depth may be missed. The master holds REQ until it sees ACK, so this is not a protocol error.
- Chirp FSM:
  - C_IDLE: RUN=0, PHASE=0, FREQ_CUR holds its last value.
    - On a start_s rising edge with CFG_VALID=1: acc<=0, FREQ_CUR<=shadow freq, rate_cnt<=shadow rate, go to C_RUN.
    - If capture and the start edge occur in the same cycle, the load takes the DDS_* inputs directly (bypass), not the stale shadow.
    - A start edge with CFG_VALID=0 is ignored.
  - C_RUN (RUN=1):
    - Every cycle: acc <= acc + FREQ_CUR, modulo 2^PHASE_W.
    - If rate≠0: rate_cnt decrements each cycle. On the cycle rate_cnt==1, FREQ_CUR <= FREQ_CUR + delta (modulo 2^PHASE_W, silent wrap) and rate_cnt reloads with the rate. The first step therefore occurs `rate` cycles after the load.
    - If rate=0: FREQ_CUR is constant.
    - start_s=0 → C_IDLE next cycle.
- Configuration arriving during C_RUN updates only the shadow registers. The active chirp is unaffected until the next start edge. This supports coherent bursts, where DDS_start stays high.
- Latency: PHASE first becomes nonzero 2 cycles after the load cycle (accumulate, then output register).
- Reset mid-run or mid-handshake: immediate return to the reset state. ACK drops asynchronously. The master must reissue REQ.

Decomposition:
- Package dds_chirp_pkg holds:
  - Width constants PHASE_W, RATE_W and OUT_W defaults.
  - An enum for the handshake states {H_IDLE, H_ACK}.
  - An enum for the chirp states {C_IDLE, C_RUN}.
  - A packed struct dds_cfg_t {freq, delta_freq, delta_rate} used for both shadow and active registers.
- Sub-module: cdc_sync_bit, a parameterized SYNC_STAGES flop chain with async reset, instanced for REQ and DDS_start.

Test Plan:
- Handshake timing: REQ=1 with freq=48'h1000, delta=48'h10, rate=4 → ACK=1 exactly 3 CLK edges later, shadow captured, CFG_VALID=1; REQ=0 → ACK=0 3 edges later.
- No sweep: freq=48'h0100_0000_0000 (1/256 of full scale), rate=0, start → PHASE sequence 0, 0x0100, 0x0200, … in OUT_W=16 bits; FREQ_CUR is constant.
- Sweep: freq=100, delta=5, rate=4 → FREQ_CUR=100 for 4 cycles, then 105, then 110, …; acc matches the reference model after 64 cycles.
- Wrap: freq=48'hFFFF_FFFF_FFFF, delta=1, rate=1 → FREQ_CUR wraps to 0 on the first step; acc wraps modulo 2^48 with no flag and no stall.
- Shadow isolation and start gating: start with no prior config → RUN stays 0. A new config (freq=200) during C_RUN → FREQ_CUR unchanged. Drop DDS_start, raise it again → FREQ_CUR=200.
- Async reset mid-run: RESET pulsed for half a cycle while RUN=1 and ACK=1 → RUN, ACK, PHASE and CFG_VALID go to 0 immediately; a subsequent start without new config is ignored.

Source files
------------

// File: rtl/dds_chirp_pkg.sv
// Shared widths, FSM state types and the DDS configuration record
// used by the chirp responder and its shadow/active register sets.
package dds_chirp_pkg;

   localparam int PHASE_W_DEF = 48;
   localparam int RATE_W_DEF  = 32;
   localparam int OUT_W_DEF   = 16;

   typedef enum logic {H_IDLE, H_ACK} hs_state_t;
   typedef enum logic {C_IDLE, C_RUN} chirp_state_t;

   typedef struct packed {
      logic [PHASE_W_DEF-1:0] freq;
      logic [PHASE_W_DEF-1:0] delta_freq;
      logic [RATE_W_DEF-1:0]  delta_rate;
   } dds_cfg_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dds_chirp_responder.sv
// REQ/ACK config receiver feeding a linear-chirp phase accumulator;
// shadow set is captured on handshake, loaded into the active set on a start edge.
module dds_chirp_responder
   import dds_chirp_pkg::*;
#(
   parameter int PHASE_W     = PHASE_W_DEF,
   parameter int RATE_W      = RATE_W_DEF,
   parameter int OUT_W       = OUT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               REQ,
   output logic               ACK,
   input  logic [PHASE_W-1:0] DDS_freq,
   input  logic [PHASE_W-1:0] DDS_delta_freq,
   input  logic [RATE_W-1:0]  DDS_delta_rate,
   input  logic               DDS_start,
   output logic [OUT_W-1:0]   PHASE,
   output logic [PHASE_W-1:0] FREQ_CUR,
   output logic               RUN,
   output logic               CFG_VALID
);

   logic               w_req_s;
   logic               w_start_s;
   logic               w_start_rise;
   logic               w_capture;
   dds_cfg_t           w_in_cfg;
   dds_cfg_t           w_load_cfg;

   hs_state_t          r_hs;
   chirp_state_t       r_cs;
   dds_cfg_t           r_shadow;
   dds_cfg_t           r_active;
   logic               r_start_d;
   logic               r_ack;
   logic               r_cfg_valid;
   logic               r_run;
   logic [PHASE_W-1:0] r_acc;
   logic [RATE_W-1:0]  r_rate_cnt;
   logic [OUT_W-1:0]   r_phase;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_d   (REQ),
      .o_q   (w_req_s)
   );

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_start_sync (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_d   (DDS_start),
      .o_q   (w_start_s)
   );

   assign w_start_rise = w_start_s & ~r_start_d;
   assign w_capture    = (r_hs == H_IDLE) && w_req_s;
   assign w_in_cfg     = {DDS_freq, DDS_delta_freq, DDS_delta_rate};
   // Same-cycle capture and start must load the incoming words, not the stale shadow.
   assign w_load_cfg   = w_capture ? w_in_cfg : r_shadow;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_hs        <= H_IDLE;
         r_shadow    <= '0;
         r_ack       <= 1'b0;
         r_cfg_valid <= 1'b0;
      end else begin
         case (r_hs)
            H_IDLE: if (w_req_s) begin
               r_shadow    <= w_in_cfg;
               r_cfg_valid <= 1'b1;
               r_ack       <= 1'b1;
               r_hs        <= H_ACK;
            end
            H_ACK: if (!w_req_s) begin
               r_ack <= 1'b0;
               r_hs  <= H_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cs       <= C_IDLE;
         r_start_d  <= 1'b0;
         r_active   <= '0;
         r_acc      <= '0;
         r_rate_cnt <= '0;
         r_phase    <= '0;
         r_run      <= 1'b0;
      end else begin
         r_start_d <= w_start_s;
         case (r_cs)
            C_IDLE: begin
               r_phase <= '0;
               r_run   <= 1'b0;
               if (w_start_rise && (r_cfg_valid || w_capture)) begin
                  r_active   <= w_load_cfg;
                  r_acc      <= '0;
                  r_rate_cnt <= w_load_cfg.delta_rate;
                  r_run      <= 1'b1;
                  r_cs       <= C_RUN;
               end
            end
            C_RUN: begin
               if (!w_start_s) begin
                  r_cs    <= C_IDLE;
                  r_run   <= 1'b0;
                  r_phase <= '0;
                  r_acc   <= '0;
               end else begin
                  r_acc   <= r_acc + r_active.freq;
                  r_phase <= r_acc[PHASE_W-1 -: OUT_W];
                  // A zero rate holds the frequency; otherwise step every `rate` cycles.
                  if (r_active.delta_rate != '0) begin
                     if (r_rate_cnt == RATE_W'(1)) begin
                        r_active.freq <= r_active.freq + r_active.delta_freq;
                        r_rate_cnt    <= r_active.delta_rate;
                     end else begin
                        r_rate_cnt <= r_rate_cnt - RATE_W'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

   assign ACK       = r_ack;
   assign CFG_VALID = r_cfg_valid;
   assign RUN       = r_run;
   assign PHASE     = r_phase;
   assign FREQ_CUR  = r_active.freq;

endmodule

// File: tb/tb_dds_chirp_responder.sv
// Randomized, model-checked bench for the chirp responder handshake and sweep.
module tb_dds_chirp_responder;

   localparam int PW = 48;
   localparam int RW = 32;
   localparam int OW = 16;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          REQ = 1'b0;
   logic          ACK;
   logic [PW-1:0] DDS_freq = '0;
   logic [PW-1:0] DDS_delta_freq = '0;
   logic [RW-1:0] DDS_delta_rate = '0;
   logic          DDS_start = 1'b0;
   logic [OW-1:0] PHASE;
   logic [PW-1:0] FREQ_CUR;
   logic          RUN;
   logic          CFG_VALID;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   dds_chirp_responder dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .REQ            (REQ),
      .ACK            (ACK),
      .DDS_freq       (DDS_freq),
      .DDS_delta_freq (DDS_delta_freq),
      .DDS_delta_rate (DDS_delta_rate),
      .DDS_start      (DDS_start),
      .PHASE          (PHASE),
      .FREQ_CUR       (FREQ_CUR),
      .RUN            (RUN),
      .CFG_VALID      (CFG_VALID)
   );

   // Frequency k cycles after load: linear staircase, one step per `r` cycles.
   function automatic logic [PW-1:0] model_freq(input logic [PW-1:0] f0, input logic [PW-1:0] d,
                                                input logic [RW-1:0] r, input int k);
      if (r == 0) return f0;
      return f0 + d * PW'(k / r);
   endfunction

   function automatic logic [PW-1:0] rnd48();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v[PW-1:0];
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic pulse_reset();
      RESET = 1'b1;
      REQ = 1'b0;
      DDS_start = 1'b0;
      step(2);
      RESET = 1'b0;
      step(2);
   endtask

   task automatic do_config(input logic [PW-1:0] f, input logic [PW-1:0] d, input logic [RW-1:0] r);
      int n;
      DDS_freq = f;
      DDS_delta_freq = d;
      DDS_delta_rate = r;
      REQ = 1'b1;
      n = 0;
      while (n < 10) begin
         step(1);
         n++;
         if (ACK) break;
      end
      n_tests++;
      if (n !== 3 || ACK !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_rise: edges=%0d ack=%b, required edges=3 ack=1", n, ACK);
      end
      n_tests++;
      if (CFG_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_valid_set: got %b, required 1", CFG_VALID);
      end
      REQ = 1'b0;
      n = 0;
      while (n < 10) begin
         step(1);
         n++;
         if (!ACK) break;
      end
      n_tests++;
      if (n !== 3 || ACK !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_fall: edges=%0d ack=%b, required edges=3 ack=0", n, ACK);
      end
      // Scramble inputs so anything loaded later must come from the captured copy.
      DDS_freq = rnd48();
      DDS_delta_freq = rnd48();
      DDS_delta_rate = $urandom;
   endtask

   task automatic start_chirp();
      int n;
      DDS_start = 1'b1;
      n = 0;
      while (n < 10) begin
         step(1);
         n++;
         if (RUN) break;
      end
      n_tests++;
      if (n !== 3 || RUN !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: edges=%0d run=%b, required edges=3 run=1", n, RUN);
      end
   endtask

   task automatic stop_chirp();
      int n;
      DDS_start = 1'b0;
      n = 0;
      while (n < 10 && RUN) begin
         step(1);
         n++;
      end
      n_tests++;
      if (RUN !== 1'b0 || PHASE !== '0) begin
         n_fail++;
         $display("FAIL stop: run=%b phase=%h, required run=0 phase=0", RUN, PHASE);
      end
      step(3);
   endtask

   // Called right after RUN rises (k=0 is the load cycle).
   task automatic check_chirp(input logic [PW-1:0] f0, input logic [PW-1:0] d,
                              input logic [RW-1:0] r, input int ncyc);
      logic [PW-1:0] acc, acc_prev, fk;
      logic [OW-1:0] exp_phase;
      int errs;
      acc = '0;
      acc_prev = '0;
      errs = 0;
      for (int k = 0; k < ncyc; k++) begin
         fk = model_freq(f0, d, r, k);
         exp_phase = (k == 0) ? '0 : acc_prev[PW-1 -: OW];
         n_tests++;
         if (FREQ_CUR !== fk || PHASE !== exp_phase || RUN !== 1'b1) begin
            n_fail++;
            if (errs < 5)
               $display("FAIL chirp k=%0d: freq=%h phase=%h run=%b, required freq=%h phase=%h run=1",
                        k, FREQ_CUR, PHASE, RUN, fk, exp_phase);
            errs++;
         end
         acc_prev = acc;
         acc = acc + fk;
         step(1);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step(3);
      n_tests++;
      if (ACK !== 1'b0 || RUN !== 1'b0 || CFG_VALID !== 1'b0 || PHASE !== '0 || FREQ_CUR !== '0) begin
         n_fail++;
         $display("FAIL reset_state: ack=%b run=%b cfg=%b phase=%h freq=%h, required all 0",
                  ACK, RUN, CFG_VALID, PHASE, FREQ_CUR);
      end
      RESET = 1'b0;
      step(2);
   endtask

   task automatic test_start_gating_and_shadow();
      DDS_start = 1'b1;
      step(8);
      n_tests++;
      if (RUN !== 1'b0 || CFG_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL start_without_cfg: run=%b cfg=%b, required run=0 cfg=0", RUN, CFG_VALID);
      end
      DDS_start = 1'b0;
      step(4);
      do_config(48'd100, 48'd0, 32'd0);
      start_chirp();
      do_config(48'd200, 48'd0, 32'd0);
      n_tests++;
      if (FREQ_CUR !== 48'd100 || RUN !== 1'b1) begin
         n_fail++;
         $display("FAIL shadow_isolation: freq=%h run=%b, required freq=%h run=1", FREQ_CUR, RUN, 48'd100);
      end
      stop_chirp();
      start_chirp();
      n_tests++;
      if (FREQ_CUR !== 48'd200) begin
         n_fail++;
         $display("FAIL shadow_reload: freq=%h, required %h", FREQ_CUR, 48'd200);
      end
      stop_chirp();
   endtask

   task automatic test_handshake();
      do_config(48'h1000, 48'h10, 32'd4);
      start_chirp();
      check_chirp(48'h1000, 48'h10, 32'd4, 12);
      stop_chirp();
   endtask

   task automatic test_no_sweep();
      do_config(48'h0100_0000_0000, 48'h5, 32'd0);
      start_chirp();
      check_chirp(48'h0100_0000_0000, 48'h5, 32'd0, 20);
      stop_chirp();
   endtask

   task automatic test_sweep();
      do_config(48'd100, 48'd5, 32'd4);
      start_chirp();
      check_chirp(48'd100, 48'd5, 32'd4, 64);
      stop_chirp();
   endtask

   task automatic test_wrap();
      do_config(48'hFFFF_FFFF_FFFF, 48'd1, 32'd1);
      start_chirp();
      check_chirp(48'hFFFF_FFFF_FFFF, 48'd1, 32'd1, 16);
      stop_chirp();
   endtask

   task automatic test_random();
      logic [PW-1:0] f, d;
      logic [RW-1:0] r;
      for (int i = 0; i < 6; i++) begin
         f = rnd48();
         d = rnd48();
         r = RW'($urandom_range(0, 6));
         do_config(f, d, r);
         start_chirp();
         check_chirp(f, d, r, 40);
         stop_chirp();
      end
   endtask

   task automatic test_bypass();
      int n;
      DDS_freq = 48'd777;
      DDS_delta_freq = 48'd3;
      DDS_delta_rate = 32'd2;
      REQ = 1'b1;
      DDS_start = 1'b1;
      n = 0;
      while (n < 10) begin
         step(1);
         n++;
         if (RUN) break;
      end
      n_tests++;
      if (n !== 3 || RUN !== 1'b1 || ACK !== 1'b1 || FREQ_CUR !== 48'd777) begin
         n_fail++;
         $display("FAIL bypass_load: edges=%0d run=%b ack=%b freq=%h, required 3 1 1 %h",
                  n, RUN, ACK, FREQ_CUR, 48'd777);
      end
      check_chirp(48'd777, 48'd3, 32'd2, 10);
      REQ = 1'b0;
      step(5);
      stop_chirp();
   endtask

   task automatic test_async_reset();
      int n;
      do_config(48'h1234_5678_9ABC, 48'd0, 32'd0);
      start_chirp();
      DDS_freq = 48'h42;
      REQ = 1'b1;
      n = 0;
      while (n < 10 && !ACK) begin
         step(1);
         n++;
      end
      n_tests++;
      if (RUN !== 1'b1 || ACK !== 1'b1 || PHASE === '0) begin
         n_fail++;
         $display("FAIL pre_reset: run=%b ack=%b phase=%h, required run=1 ack=1 phase!=0", RUN, ACK, PHASE);
      end
      @(negedge CLK);
      RESET = 1'b1;
      REQ = 1'b0;
      #1;
      n_tests++;
      if (RUN !== 1'b0 || ACK !== 1'b0 || PHASE !== '0 || CFG_VALID !== 1'b0 || FREQ_CUR !== '0) begin
         n_fail++;
         $display("FAIL async_reset: run=%b ack=%b phase=%h cfg=%b freq=%h, required all 0",
                  RUN, ACK, PHASE, CFG_VALID, FREQ_CUR);
      end
      #3;
      RESET = 1'b0;
      step(10);
      n_tests++;
      if (RUN !== 1'b0 || CFG_VALID !== 1'b0 || ACK !== 1'b0) begin
         n_fail++;
         $display("FAIL start_after_reset: run=%b cfg=%b ack=%b, required all 0", RUN, CFG_VALID, ACK);
      end
      DDS_start = 1'b0;
      step(4);
      DDS_start = 1'b1;
      step(8);
      n_tests++;
      if (RUN !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_after_reset: run=%b, required 0", RUN);
      end
      DDS_start = 1'b0;
      step(2);
   endtask

   initial begin
      test_reset();
      test_start_gating_and_shadow();
      test_handshake();
      test_no_sweep();
      test_sweep();
      test_wrap();
      test_random();
      test_bypass();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
